// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: turns single-cycle burst requests into BURSTLEN
// per-word memory cycles with critical-word-first wrap inside an aligned block.
module mem_burst_ctrl #(
  parameter  int BUSWIDTH  = 16,
  parameter  int MEMSIZE   = 256,
  parameter  int BURSTLEN  = 4,
  localparam int ADDRWIDTH = $clog2(MEMSIZE),
  localparam int BEATW     = $clog2(BURSTLEN)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 AddrValid,
  input  logic                 rw,
  input  logic [ADDRWIDTH-1:0] Addr,
  input  logic [BUSWIDTH-1:0]  WrData,
  output logic [BUSWIDTH-1:0]  RdData,
  output logic                 RdValid,
  output logic                 Busy,
  output logic                 mem_rdEn,
  output logic                 mem_wrEn,
  output logic [ADDRWIDTH-1:0] mem_Addr,
  output logic [BUSWIDTH-1:0]  mem_DataOut,
  input  logic [BUSWIDTH-1:0]  mem_DataIn
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [ADDRWIDTH-1:0] BEAT_MASK = ADDRWIDTH'(BURSTLEN - 1);
  localparam logic [BEATW:0]       LAST_BEAT = (BEATW + 1)'(BURSTLEN - 1);

  state_e                state_q, state_d;
  logic [ADDRWIDTH-1:0]  base_q, base_d;
  logic [BEATW:0]        beat_q, beat_d;
  logic [BUSWIDTH-1:0]   rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDRWIDTH-1:0]  beat_addr;

  // Upper bits stay fixed; only the in-block offset advances and wraps.
  assign beat_addr = (base_q & ~BEAT_MASK) |
                     ((base_q + ADDRWIDTH'(beat_q)) & BEAT_MASK);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    beat_d      = beat_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    mem_rdEn    = 1'b0;
    mem_wrEn    = 1'b0;
    mem_Addr    = '0;
    mem_DataOut = '0;

    unique case (state_q)
      IDLE: begin
        if (AddrValid) begin
          base_d  = Addr;
          beat_d  = '0;
          state_d = rw ? READ : WRITE;
        end
      end
      READ: begin
        mem_rdEn   = 1'b1;
        mem_Addr   = beat_addr;
        rd_data_d  = mem_DataIn;
        rd_valid_d = 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WRITE: begin
        mem_wrEn    = 1'b1;
        mem_Addr    = beat_addr;
        mem_DataOut = WrData;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        beat_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Control and read-return registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Burst base is only consulted outside IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;
  assign Busy    = (state_q != IDLE);

endmodule
